regfile_scan_reader: RTL

- Read-side counterpart to the switch-driven register-file loader on the board.
- Walks the register file's A read port through R0..R15, then PC, and latches each value into the 33-bit display word consumed by Display.
- Sits between the button inputs, RegFile_plus (R_Addr_A, R_Data_A, PC) and Display (data).
- Advances on a debounced step button; compile-time option adds timed auto-advance.

---
 rtl/regfile_scan_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_scan_reader.sv
// Steps the regfile A port through R0..R15 then PC, latching each value into the 33-bit display word.
// Optional AUTO_SCAN_EN adds timed auto-advance after DWELL_CYCLES in SHOW.
module regfile_scan_reader #(
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned DWELL_CYCLES = 100,
    parameter int unsigned LAST_IDX     = 16
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        start,
    input  logic        stop,
    input  logic        step,
    input  logic [31:0] R_Data,
    input  logic [31:0] PC,
    output logic [3:0]  R_Addr,
    output logic [32:0] data,
    output logic [4:0]  idx,
    output logic        busy
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [32:0] BLANK = {32'h8888_8888, 1'b0};

    typedef enum logic [1:0] {IDLE, SETUP, CAPTURE, SHOW} state_t;

    state_t             state, state_d;
    logic               step_meta, step_sync;
    logic [DEB_W-1:0]   deb_cnt;
    logic               deb_level;
    logic               step_pulse;
    logic               dwell_exp;
    logic               advance;
    logic [4:0]         idx_nxt;
    logic [4:0]         idx_d;
    logic [3:0]         addr_d;
    logic [32:0]        data_d;
    logic               busy_d;

    // Two-flop synchronizer for the raw push button
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES consecutive cycles
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            deb_cnt    <= '0;
            deb_level  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (step_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb_cnt    <= '0;
                deb_level  <= step_sync;
                step_pulse <= step_sync;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

`ifdef AUTO_SCAN_EN
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);
    logic [DWELL_W-1:0] dwell_cnt;

    // Dwell restarts every time SHOW is entered
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            dwell_cnt <= '0;
        end else if (state != SHOW) begin
            dwell_cnt <= '0;
        end else if (!dwell_exp) begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end

    assign dwell_exp = (state == SHOW) && (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
`else
    // Manual stepping only; DWELL_CYCLES kept so both builds share one interface
    assign dwell_exp = 1'b0 & (DWELL_CYCLES == 0);
`endif

    assign advance = step_pulse | dwell_exp;
    assign idx_nxt = (idx == 5'(LAST_IDX)) ? 5'd0 : idx + 5'd1;

    // State and registered outputs
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            idx    <= 5'd0;
            R_Addr <= 4'd0;
            data   <= BLANK;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            R_Addr <= addr_d;
            data   <= data_d;
            busy   <= busy_d;
        end
    end

    // Next-state logic; stop overrides everything else
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   state_d = CAPTURE;
            CAPTURE: state_d = SHOW;
            SHOW:    if (advance) state_d = SETUP;
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end

    // Next values of the registered outputs
    always_comb begin
        idx_d  = idx;
        addr_d = R_Addr;
        data_d = data;
        case (state)
            IDLE: begin
                data_d = BLANK;
                if (start) begin
                    idx_d  = 5'd0;
                    addr_d = 4'd0;
                end
            end
            CAPTURE: data_d = (idx < 5'd16) ? {R_Data, 1'b1} : {PC, 1'b1};
            SHOW: begin
                if (advance) begin
                    idx_d  = idx_nxt;
                    addr_d = idx_nxt[3:0];
                end
            end
            default: ;
        endcase
        if (stop) begin
            idx_d  = 5'd0;
            addr_d = 4'd0;
            data_d = BLANK;
        end
        busy_d = (state_d != IDLE);
    end

endmodule
